// File: rtl/pkt_responder.sv
// pkt_responder: register-file responder behind a valid/ready request channel.
// Each accepted request (WRITE / READ / INC / illegal) runs against a
// 2**ADDR_W-entry register file. It produces exactly one in-order response
// through a 2-entry queue onto a valid/ready response channel.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_op/id/addr/data     request fields (op: 00 illegal, 01 WRITE, 10 READ, 11 INC)
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/data/status      response fields (status: 00 OK, 01 ERR, 10 OVF)
//   err_count               saturating count of illegal-op requests
module pkt_responder #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ID_W-1:0]   req_id,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_INC     = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_ERR = 2'b01,
        ST_OVF = 2'b10
    } status_e;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Queue = head (the rsp_* output registers) + one spill entry behind it.
    // Keeping the head in the output registers makes the response fields hold
    // their last value once the queue empties.
    logic              q1_valid;
    logic [ID_W-1:0]   q1_id;
    logic [DATA_W-1:0] q1_data;
    status_e           q1_status;

    op_e               op;
    logic              accept;
    logic              pop;
    logic [DATA_W:0]   sum;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] new_data;
    status_e           new_status;
    logic              is_illegal;

    assign op        = op_e'(req_op);
    assign req_ready = !(rsp_valid && q1_valid);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        sum        = {1'b0, mem[req_addr]} + {1'b0, req_data};
        mem_we     = 1'b0;
        mem_wdata  = req_data;
        new_data   = '0;
        new_status = ST_OK;
        is_illegal = 1'b0;
        case (op)
            OP_WRITE: begin
                mem_we   = 1'b1;
                new_data = req_data;
            end
            OP_READ: begin
                new_data = mem[req_addr];
            end
            OP_INC: begin
                mem_we     = 1'b1;
                mem_wdata  = sum[DATA_W-1:0];
                new_data   = sum[DATA_W-1:0];
                new_status = sum[DATA_W] ? ST_OVF : ST_OK;
            end
            default: begin
                new_status = ST_ERR;
                is_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && mem_we) begin
            mem[req_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && is_illegal && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    // A push can coincide with a pop only when the spill entry is empty,
    // because req_ready is low whenever both entries are occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
            q1_valid   <= 1'b0;
            q1_id      <= '0;
            q1_data    <= '0;
            q1_status  <= ST_OK;
        end else if (pop) begin
            if (q1_valid) begin
                rsp_id     <= q1_id;
                rsp_data   <= q1_data;
                rsp_status <= q1_status;
                q1_valid   <= 1'b0;
            end else if (accept) begin
                rsp_id     <= req_id;
                rsp_data   <= new_data;
                rsp_status <= new_status;
            end else begin
                rsp_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!rsp_valid) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= req_id;
                rsp_data   <= new_data;
                rsp_status <= new_status;
            end else begin
                q1_valid  <= 1'b1;
                q1_id     <= req_id;
                q1_data   <= new_data;
                q1_status <= new_status;
            end
        end
    end

endmodule

// File: tb/tb_pkt_responder.sv
// tb_pkt_responder: directed self-checking bench for pkt_responder.
// Ports of the DUT are driven just after the rising edge and sampled either
// at the falling edge or 1 time unit after the rising edge.
module tb_pkt_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_id = '0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_id;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic [7:0] err_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pkt_responder #(.ADDR_W(4), .DATA_W(8), .ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_status(rsp_status), .err_count(err_count)
    );

    // Presents one request and returns 1 unit after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [3:0] id,
                        input logic [3:0] addr, input logic [7:0] data);
        int waited = 0;
        req_op = op; req_id = id; req_addr = addr; req_data = data;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_assert++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_accept id=%0d: req_ready=%b required 1", id, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_assert++;
        if ({rsp_valid, req_ready, rsp_id, rsp_data, rsp_status, err_count} !==
            {1'b0, 1'b1, 4'd0, 8'd0, 2'b00, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b id=%h data=%h st=%b err=%h required 0 1 0 00 00 00",
                     rsp_valid, req_ready, rsp_id, rsp_data, rsp_status, err_count);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        send(2'b01, 4'd1, 4'd3, 8'hA5);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd1, 8'hA5, 2'b00}) begin
            n_fail++;
            $display("FAIL write_rsp: valid=%b id=%0d data=%h st=%b required 1 1 a5 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
        send(2'b10, 4'd2, 4'd3, 8'h00);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd2, 8'hA5, 2'b00}) begin
            n_fail++;
            $display("FAIL read_rsp: valid=%b id=%0d data=%h st=%b required 1 2 a5 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
    endtask

    task automatic test_inc();
        drain();
        send(2'b11, 4'd3, 4'd5, 8'hF0);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd3, 8'hF0, 2'b00}) begin
            n_fail++;
            $display("FAIL inc1_rsp: valid=%b id=%0d data=%h st=%b required 1 3 f0 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
        send(2'b11, 4'd4, 4'd5, 8'hF0);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd4, 8'hE0, 2'b10}) begin
            n_fail++;
            $display("FAIL inc2_ovf: valid=%b id=%0d data=%h st=%b required 1 4 e0 10",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
        send(2'b10, 4'd5, 4'd5, 8'h00);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd5, 8'hE0, 2'b00}) begin
            n_fail++;
            $display("FAIL inc_readback: valid=%b id=%0d data=%h st=%b required 1 5 e0 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        rsp_ready = 1'b0;
        req_op = 2'b01; req_id = 4'd6; req_addr = 4'd1; req_data = 8'h11; req_valid = 1'b1;
        @(posedge clk); #1;
        req_id = 4'd7; req_addr = 4'd2; req_data = 8'h22;
        @(posedge clk); #1;
        req_id = 4'd8; req_addr = 4'd3; req_data = 8'h33;
        n_assert++;
        if ({req_ready, rsp_valid, rsp_id} !== {1'b0, 1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b valid=%b id=%0d required 0 1 6", req_ready, rsp_valid, rsp_id);
        end
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data} !== {1'b0, 1'b1, 4'd6, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_hold: ready=%b valid=%b id=%0d data=%h required 0 1 6 11",
                     req_ready, rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'd7, 8'h22}) begin
            n_fail++;
            $display("FAIL bp_pop1: ready=%b valid=%b id=%0d data=%h required 1 1 7 22",
                     req_ready, rsp_valid, rsp_id, rsp_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd8, 8'h33, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_third: valid=%b id=%0d data=%h st=%b required 1 8 33 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
        @(posedge clk); #1;
        n_assert++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] exp_err;
        drain();
        req_op = 2'b00; req_data = 8'hFF; req_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            req_id   = 4'(i);
            req_addr = 4'(i);
            @(posedge clk); #1;
            exp_err = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            n_assert++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_status, err_count} !==
                {1'b1, 4'(i), 8'h00, 2'b01, exp_err}) begin
                n_fail++;
                $display("FAIL illegal_%0d: valid=%b id=%0d data=%h st=%b err=%0d required 1 %0d 00 01 %0d",
                         i, rsp_valid, rsp_id, rsp_data, rsp_status, err_count, i % 16, exp_err);
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        send(2'b10, 4'd9, 4'd1, 8'h00);
        n_assert++;
        if ({rsp_id, rsp_data} !== {4'd9, 8'h11}) begin
            n_fail++;
            $display("FAIL illegal_keep1: id=%0d data=%h required 9 11", rsp_id, rsp_data);
        end
        send(2'b10, 4'd10, 4'd3, 8'h00);
        n_assert++;
        if ({rsp_id, rsp_data} !== {4'd10, 8'h33}) begin
            n_fail++;
            $display("FAIL illegal_keep3: id=%0d data=%h required 10 33", rsp_id, rsp_data);
        end
        send(2'b10, 4'd11, 4'd5, 8'h00);
        n_assert++;
        if ({rsp_id, rsp_data, err_count} !== {4'd11, 8'hE0, 8'hFF}) begin
            n_fail++;
            $display("FAIL illegal_keep5: id=%0d data=%h err=%h required 11 e0 ff", rsp_id, rsp_data, err_count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] model [16];
        logic [7:0] exp_data;
        logic [1:0] exp_st;
        logic [8:0] s;
        logic [1:0] op;
        logic [3:0] a;
        logic [7:0] d;
        drain();
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        model[1] = 8'h11; model[2] = 8'h22; model[3] = 8'h33; model[5] = 8'hE0;
        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(1, 3));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            exp_st = 2'b00;
            if (op == 2'b01) begin
                exp_data = d;
                model[a] = d;
            end else if (op == 2'b10) begin
                exp_data = model[a];
            end else begin
                s = {1'b0, model[a]} + {1'b0, d};
                exp_data = s[7:0];
                exp_st = s[8] ? 2'b10 : 2'b00;
                model[a] = s[7:0];
            end
            req_op = op; req_id = 4'(i); req_addr = a; req_data = d; req_valid = 1'b1;
            @(negedge clk);
            n_assert++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready_%0d: ready=%b required 1", i, req_ready);
            end
            @(posedge clk); #1;
            n_assert++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'(i), exp_data, exp_st}) begin
                n_fail++;
                $display("FAIL stream_rsp_%0d: valid=%b id=%0d data=%h st=%b required 1 %0d %h %b",
                         i, rsp_valid, rsp_id, rsp_data, rsp_status, i % 16, exp_data, exp_st);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        drain();
        rsp_ready = 1'b0;
        req_op = 2'b01; req_id = 4'd1; req_addr = 4'd7; req_data = 8'h77; req_valid = 1'b1;
        @(posedge clk); #1;
        req_id = 4'd2; req_addr = 4'd8; req_data = 8'h88;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_assert++;
        if ({rsp_valid, req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_full: valid=%b ready=%b required 1 0", rsp_valid, req_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({rsp_valid, req_ready, rsp_id, rsp_data, err_count} !== {1'b0, 1'b1, 4'd0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b ready=%b id=%0d data=%h err=%h required 0 1 0 00 00",
                     rsp_valid, req_ready, rsp_id, rsp_data, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_stale: valid=%b required 0", rsp_valid);
        end
        send(2'b10, 4'd3, 4'd7, 8'h00);
        n_assert++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_status} !== {1'b1, 4'd3, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL rstmid_read7: valid=%b id=%0d data=%h st=%b required 1 3 00 00",
                     rsp_valid, rsp_id, rsp_data, rsp_status);
        end
        send(2'b10, 4'd4, 4'd1, 8'h00);
        n_assert++;
        if ({rsp_id, rsp_data} !== {4'd4, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_read1: id=%0d data=%h required 4 00", rsp_id, rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_inc();
        test_back_to_back();
        test_illegal();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
